// File: rtl/pcie_byte_tx_arbiter_if.sv
// Byte-TX arbiter bus: per-source request lanes, TX handshake and status.
// The arbiter takes the slave view; sources and the byte TX sit on master.
interface pcie_byte_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 TX_READY;
    logic [7:0]           DATA;
    logic                 Valid;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 err_trunc;

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  TX_READY,
        output req_ready,
        output DATA,
        output Valid,
        output grant,
        output busy,
        output err_trunc
    );

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output TX_READY,
        input  req_ready,
        input  DATA,
        input  Valid,
        input  grant,
        input  busy,
        input  err_trunc
    );
endinterface

// File: rtl/pcie_byte_tx_arbiter.sv
// Packet-granular round-robin arbiter for the shared PCIe byte-TX lane.
// Define PCIE_ARB_PRIO0_EN to give source 0 strict priority at arbitration.
module pcie_byte_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_PKT = 64,
    parameter int IPG     = 1
) (
    input  logic CLK,
    input  logic RESET,
    pcie_byte_tx_arbiter_if.slave bus
);
    localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW1 = PW + 1;

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t state;
    state_t state_nx;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      own;
    logic [PW-1:0]      win;
    logic [PW:0]        idx;
    logic               found;
    logic               upd_ptr;
    logic [7:0]         cnt;
    logic [1:0]         gcnt;
    logic [7:0]         data_q;
    logic               valid_q;
    logic               err_q;
    logic [NUM_REQ-1:0] own_oh;
    logic               any_req;
    logic               acc;
    logic               lst;
    logic               lim;
    logic               fin;

    assign any_req = |bus.req_valid;
    assign own_oh  = NUM_REQ'(1) << own;
    assign acc     = (state == XFER) & bus.TX_READY & bus.req_valid[own];
    assign lst     = bus.req_last[own];
    assign lim     = (cnt == 8'(MAX_PKT - 1));
    assign fin     = acc & (lst | lim);

    // Search starts one past the last winner so every source gets a turn.
    always_comb begin
        win     = ptr;
        idx     = '0;
        found   = 1'b0;
        upd_ptr = 1'b1;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = {1'b0, ptr} + PW1'(i);
            if (idx >= PW1'(NUM_REQ))
                idx = idx - PW1'(NUM_REQ);
            if (!found && bus.req_valid[idx[PW-1:0]]) begin
                win   = idx[PW-1:0];
                found = 1'b1;
            end
        end
`ifdef PCIE_ARB_PRIO0_EN
        // Source 0 wins without disturbing the rotation of the others.
        if (bus.req_valid[0]) begin
            win     = '0;
            upd_ptr = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (any_req)
                    state_nx = XFER;
            end
            XFER: begin
                if (fin)
                    state_nx = (IPG == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gcnt == 2'(IPG - 1))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.grant     = '0;
        bus.busy      = (state != IDLE);
        if (state == XFER) begin
            bus.grant = own_oh;
            if (bus.TX_READY)
                bus.req_ready = own_oh;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr     <= PW'(NUM_REQ - 1);
            own     <= '0;
            cnt     <= '0;
            gcnt    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= acc;
            // Truncation only when the limit byte is not also the packet end.
            err_q   <= acc & lim & ~lst;
            gcnt    <= (state == GAP) ? gcnt + 2'd1 : 2'd0;
            if (acc) begin
                data_q <= bus.req_data[{own, 3'b000} +: 8];
                cnt    <= cnt + 8'd1;
            end
            if (state == IDLE && any_req) begin
                own <= win;
                cnt <= '0;
                if (upd_ptr)
                    ptr <= win;
            end
        end
    end

    assign bus.DATA      = data_q;
    assign bus.Valid     = valid_q;
    assign bus.err_trunc = err_q;
endmodule

// File: tb/tb_pcie_byte_tx_arbiter.sv
// Scoreboard bench for pcie_byte_tx_arbiter: random sources vs a
// transaction-level model of round-robin packet arbitration.
module tb_pcie_byte_tx_arbiter;
    localparam int NR = 4;
    localparam int MP = 64;
    localparam int IG = 1;
    localparam int SW = $clog2(NR);

    typedef struct {
        logic [7:0] d;
        logic       t;
        int         c;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [8:0] srcq [NR][$];
    int         sidx [NR];
    exp_t       expq [$];
    int         glog [$];
    int         eg [8];

    int vprob = 100;
    int tprob = 100;
    int stall_lo = 0;
    int stall_hi = 0;
    int rst_cyc = -1;
    bit hold_rst = 1'b1;
    bit chk_en = 1'b0;
    bit mon_en = 1'b0;
    int nvalid = 0;
    int ntrunc = 0;
    int pc = 0;

    int m_own = -1;
    int m_gap = 0;
    int m_ptr = NR - 1;
    int m_cnt = 0;

    pcie_byte_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    pcie_byte_tx_arbiter #(
        .NUM_REQ(NR),
        .MAX_PKT(MP),
        .IPG(IG)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d",
                     nm, act, req, cyc);
        end
    endtask

    task automatic load_pkt(input int s, input int len,
                            input logic [7:0] b0, input bit lastf);
        for (int k = 0; k < len; k++)
            srcq[s].push_back({lastf && (k == len - 1), 8'(b0 + k)});
    endtask

    // Driver plus reference model: inputs change at negedge, the model
    // consumes the values presented just before the next posedge.
    initial begin : drv
        logic [8:0]    ent;
        logic [8:0]    e2;
        logic [SW-1:0] mo;
        logic [NR-1:0] eg_oh;
        logic          lst;
        int            w;
        int            j;
        RESET = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.TX_READY = 1'b0;
        forever begin
            @(negedge CLK);
            RESET = hold_rst || (cyc == rst_cyc);
            for (int i = 0; i < NR; i++) begin
                if (srcq[i].size() > 0 && $urandom_range(99) < vprob) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_data[i*8 +: 8] = srcq[i][0][7:0];
                    bus.req_last[i] = srcq[i][0][8];
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_data[i*8 +: 8] = 8'($urandom);
                    bus.req_last[i] = 1'($urandom);
                end
            end
            if (cyc >= stall_lo && cyc < stall_hi)
                bus.TX_READY = 1'b0;
            else
                bus.TX_READY = ($urandom_range(99) < tprob);
            #4;
            if (RESET) begin
                m_own = -1;
                m_gap = 0;
                m_ptr = NR - 1;
                m_cnt = 0;
                for (int i = 0; i < NR; i++) begin
                    srcq[i].delete();
                    sidx[i] = 0;
                end
            end else begin
                mo = SW'(m_own < 0 ? 0 : m_own);
                eg_oh = (m_own >= 0) ? (NR'(1) << mo) : '0;
                if (chk_en) begin
                    chk("grant", bus.grant, eg_oh);
                    chk("busy", bus.busy, (m_own >= 0) || (m_gap > 0));
                    chk("req_ready", bus.req_ready,
                        bus.TX_READY ? eg_oh : '0);
                end
                for (int i = 0; i < NR; i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) begin
                        ent = srcq[i].pop_front();
                        sidx[i]++;
                        if (!ent[8] && sidx[i] == MP) begin
                            while (srcq[i].size() > 0) begin
                                e2 = srcq[i].pop_front();
                                if (e2[8]) break;
                            end
                        end
                        if (ent[8] || sidx[i] == MP)
                            sidx[i] = 0;
                    end
                end
                if (m_own >= 0) begin
                    if (bus.TX_READY && bus.req_valid[mo]) begin
                        m_cnt++;
                        lst = bus.req_last[mo];
                        expq.push_back('{d: bus.req_data[m_own*8 +: 8],
                                         t: (!lst && m_cnt == MP),
                                         c: cyc + 1});
                        if (lst || m_cnt == MP) begin
                            m_own = -1;
                            m_gap = IG;
                        end
                    end
                end else if (m_gap > 0) begin
                    m_gap--;
                end else if (bus.req_valid != '0) begin
                    w = -1;
`ifdef PCIE_ARB_PRIO0_EN
                    if (bus.req_valid[0]) w = 0;
`endif
                    if (w < 0) begin
                        for (int k = 1; k <= NR; k++) begin
                            j = (m_ptr + k) % NR;
                            if (w < 0 && bus.req_valid[j]) w = j;
                        end
                        m_ptr = w;
                    end
                    m_own = w;
                    m_cnt = 0;
                end
            end
        end
    end

    initial begin : mon
        exp_t          e;
        logic [NR-1:0] pg;
        pg = '0;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                while (expq.size() > 0 && expq[0].c < cyc) begin
                    e = expq.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL out_missing byte=%0h due=%0d now=%0d",
                             e.d, e.c, cyc);
                end
                if (bus.Valid === 1'b1) begin
                    nvalid++;
                    if (expq.size() > 0 && expq[0].c == cyc) begin
                        e = expq.pop_front();
                        chk("out_data", bus.DATA, e.d);
                        chk("out_trunc", bus.err_trunc, e.t);
                    end else begin
                        chk("out_valid", bus.Valid, 0);
                    end
                end else begin
                    if (expq.size() > 0 && expq[0].c == cyc) begin
                        void'(expq.pop_front());
                        chk("out_valid", bus.Valid, 1);
                    end
                    chk("idle_trunc", bus.err_trunc, 0);
                end
                if (bus.err_trunc === 1'b1) ntrunc++;
                if (bus.grant !== '0 && bus.grant !== pg)
                    glog.push_back(int'(bus.grant));
                pg = bus.grant;
            end
        end
    end

    task automatic do_reset();
        @(posedge CLK);
        #1;
        hold_rst = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        hold_rst = 1'b0;
    endtask

    task automatic start_phase();
        @(posedge CLK);
        #1;
        glog.delete();
        nvalid = 0;
        ntrunc = 0;
        pc = cyc;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        bit busy_src;
        n = 0;
        forever begin
            busy_src = 1'b0;
            for (int i = 0; i < NR; i++)
                if (srcq[i].size() > 0) busy_src = 1'b1;
            if (!busy_src && m_own < 0 && m_gap == 0 && expq.size() == 0)
                break;
            if (n >= bound) break;
            @(posedge CLK);
            n++;
        end
        if (n >= bound) begin
            checks++;
            errors++;
            $display("FAIL timeout after %0d cycles", bound);
        end
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic check_glog(input string nm, input int n);
        chk({nm, "_count"}, glog.size(), n);
        for (int k = 0; k < n; k++)
            if (k < glog.size()) chk(nm, glog[k], eg[k]);
    endtask

    initial begin : main
        int tot;
        int ntr;
        int len;
        do_reset();
        chk_en = 1'b1;
        mon_en = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_data", bus.DATA, 0);
        chk("rst_valid", bus.Valid, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err_trunc, 0);

        start_phase();
        load_pkt(1, 3, 8'hA1, 1'b1);
        wait_idle(200);
        eg = '{2, 0, 0, 0, 0, 0, 0, 0};
        check_glog("single_grant", 1);
        chk("single_bytes", nvalid, 3);

        do_reset();
        start_phase();
        for (int i = 0; i < NR; i++) begin
            load_pkt(i, 2, 8'(8'h10 * (i + 1)), 1'b1);
            load_pkt(i, 2, 8'(8'h10 * (i + 1) + 8), 1'b1);
        end
        wait_idle(400);
        eg = '{1, 2, 4, 8, 1, 2, 4, 8};
        check_glog("rr_order", 8);
        chk("rr_bytes", nvalid, 16);

        do_reset();
        start_phase();
        load_pkt(2, 70, 8'h00, 1'b0);
        load_pkt(3, 3, 8'hE0, 1'b1);
        wait_idle(600);
        eg = '{4, 8, 0, 0, 0, 0, 0, 0};
        check_glog("trunc_grant", 2);
        chk("trunc_pulses", ntrunc, 1);
        chk("trunc_bytes", nvalid, 67);

        do_reset();
        start_phase();
        stall_lo = pc + 3;
        stall_hi = pc + 8;
        load_pkt(0, 8, 8'h50, 1'b1);
        while (cyc < pc + 5) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("stall_ready", bus.req_ready, 0);
        chk("stall_grant", bus.grant, 1);
        chk("stall_valid", bus.Valid, 0);
        wait_idle(200);
        eg = '{1, 0, 0, 0, 0, 0, 0, 0};
        check_glog("stall_grant_log", 1);
        chk("stall_bytes", nvalid, 8);

        do_reset();
        start_phase();
        load_pkt(0, 4, 8'hB0, 1'b1);
        rst_cyc = pc + 2;
        while (cyc < pc + 3) @(posedge CLK);
        #1;
        chk("midrst_valid", bus.Valid, 0);
        chk("midrst_grant", bus.grant, 0);
        chk("midrst_busy", bus.busy, 0);
        rst_cyc = -1;
        repeat (2) @(posedge CLK);
        start_phase();
        load_pkt(3, 2, 8'hC0, 1'b1);
        load_pkt(0, 2, 8'hD0, 1'b1);
        wait_idle(200);
        eg = '{1, 8, 0, 0, 0, 0, 0, 0};
        check_glog("midrst_order", 2);

        do_reset();
        start_phase();
        tot = 0;
        ntr = 0;
        for (int i = 0; i < NR; i++) begin
            for (int p = 0; p < 6; p++) begin
                len = $urandom_range(1, 80);
                load_pkt(i, len, 8'($urandom), 1'b1);
                tot += (len > MP) ? MP : len;
                if (len > MP) ntr++;
            end
        end
        vprob = 70;
        tprob = 75;
        wait_idle(20000);
        chk("rand_bytes", nvalid, tot);
        chk("rand_trunc", ntrunc, ntr);
        vprob = 100;
        tprob = 100;

        do_reset();
        start_phase();
        for (int p = 0; p < 3; p++) begin
            load_pkt(0, 2, 8'(8'h60 + 2 * p), 1'b1);
            load_pkt(1, 2, 8'(8'h70 + 2 * p), 1'b1);
        end
        wait_idle(300);
`ifdef PCIE_ARB_PRIO0_EN
        eg = '{1, 1, 1, 2, 2, 2, 0, 0};
`else
        eg = '{1, 2, 1, 2, 1, 2, 0, 0};
`endif
        check_glog("src01_order", 6);

        do_reset();
        start_phase();
        for (int p = 0; p < 2; p++) begin
            load_pkt(1, 2, 8'(8'h80 + 2 * p), 1'b1);
            load_pkt(2, 2, 8'(8'h90 + 2 * p), 1'b1);
        end
        wait_idle(300);
        eg = '{2, 4, 2, 4, 0, 0, 0, 0};
        check_glog("src12_order", 4);

        chk("final_queue", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcie_byte_tx_arbiter.md
Name: pcie_byte_tx_arbiter

Overview:
Shares the single 8-bit byte-TX datapath (DATA/Valid into the PCIe byte serializer) among NUM_REQ packet sources.
- Round-robin, packet-granular arbitration: once a source is granted, it owns the lane until it sends its last byte or hits the length limit.
- Enforces a minimum inter-packet gap.
- Registers the outgoing byte stream. Sits between the transaction-layer source FIFOs and the byte TX.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_PKT, 64, max bytes per grant before forced release (1..255).
- IPG, 1, idle cycles inserted after each packet (0..3).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-source byte available.
- req_data  in  8*NUM_REQ  per-source byte; source i on bits [8i+7:8i].
- req_last  in  NUM_REQ  per-source last-byte-of-packet flag.
- req_ready  out  NUM_REQ  per-source byte accepted this cycle (combinational).
- TX_READY  in  1  byte TX can take a byte next cycle.
- DATA  out  8  registered byte to byte TX.
- Valid  out  1  registered; DATA valid.
- grant  out  NUM_REQ  one-hot owner; 0 when none.
- busy  out  1  state != IDLE.
- err_trunc  out  1  one-cycle pulse on forced release.

Behaviour:
- States: IDLE, XFER, GAP. Reset to IDLE.
- Reset values: DATA=8'h00, Valid=0, grant=0, busy=0, err_trunc=0, byte count=0, last-grant pointer=NUM_REQ-1 (so source 0 wins first).
- IDLE, any req_valid=1:
  - Pick the first set bit searching from pointer+1 upward, with wrap.
  - Next cycle: grant=onehot(winner), pointer=winner, state=XFER, count=0.
  - No request: remain in IDLE.
- XFER:
  - req_ready[g] = TX_READY & (state==XFER); all other req_ready bits are 0.
  - Accept = req_valid[g] & req_ready[g].
  - On accept: next cycle DATA=req_data[g], Valid=1, count+1. Otherwise Valid=0 and DATA holds its value.
  - Per-source byte order is preserved. No byte is duplicated or dropped.
- Packet end:
  - Accept with req_last[g]=1 → GAP (or IDLE if IPG=0); grant cleared next cycle.
  - Accept with count==MAX_PKT-1 and req_last=0 → forced release. err_trunc=1 for one cycle, then GAP/IDLE. The source is responsible for discarding the remainder of that packet.
  - req_last and limit hit on the same accept → normal end; err_trunc stays 0.
- GAP: Valid=0, grant=0 for exactly IPG cycles, then IDLE. Requests are ignored during GAP.
- Latency: req_valid rising in IDLE at cycle n → grant at n+1 → first Valid at n+2 (if TX_READY=1).
- TX_READY=0 in XFER: no accept, grant held indefinitely, count frozen.
- req_valid[g] low mid-packet: grant is held (bubble); Valid=0 for those cycles.
- Requests changing on other lanes during XFER have no effect.
- RESET asserted mid-packet: next cycle all state and outputs return to reset values; the pointer returns to NUM_REQ-1.

Optional Feature:
PCIE_ARB_PRIO0_EN
- Defined: source 0 is strict high priority. In IDLE, if req_valid[0]=1, source 0 wins regardless of the pointer, and the pointer is not updated on source-0 wins. Other sources use round-robin among themselves.
- Undefined: pure round-robin as described above.
- Preemption mid-packet never occurs in either mode.

Test Plan:
- Reset, then source 1 sends 3 bytes (0xA1, 0xA2, 0xA3 last), TX_READY=1 → grant=4'b0010 at n+1; DATA = A1, A2, A3 at n+2..n+4 with Valid=1; one Valid=0 gap cycle (IPG=1); then grant=0.
- Sources 0–3 all request continuously with 2-byte packets → grant order 0,1,2,3,0. No interleaving of bytes between sources.
- Source 2 sends 70 bytes, no last, MAX_PKT=64 → exactly 64 bytes output; err_trunc pulses once on the cycle after byte 64; source 3 is then granted if requesting.
- TX_READY=0 for 5 cycles mid-packet on source 0 → Valid=0, req_ready=0, grant held. Stream resumes with the next byte; no loss or duplicate.
- RESET asserted on the 2nd byte of a 4-byte packet → next cycle Valid=0, grant=0, busy=0. A later request from source 3 alongside source 0 grants source 0 first.
- PCIE_ARB_PRIO0_EN defined, sources 0 and 1 requesting repeatedly → source 0 granted every arbitration. With source 0 idle, sources 1 and 2 alternate.
